iter_mult: RTL and testbench

Parametrised iterative shift-add multiplier/squarer with a runtime signed/unsigned mode and valid/ready handshakes on both sides. It generalises the team's fixed 33-bit combinational square helper into a sequential, width-configurable arithmetic unit. It handles one operation at a time, taking WIDTH cycles per product. It sits between a request producer and a result consumer, both of which may stall.

---
 rtl/iter_mult.sv | 91 +++++++++
 tb/tb_iter_mult.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier/squarer, one product per WIDTH cycles.
// Signed operands are reduced to magnitudes up front; the sign is reapplied at the final load.
module iter_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sq,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH:0]    mcand, mplier;
    logic              neg;
    logic [PW-1:0]     acc;
    logic [CW-1:0]     count;

    logic [WIDTH-1:0]  b_sel;
    logic [PW-1:0]     acc_sum;
    logic              accept, last_iter;

    // One extra bit so that the most negative value has a representable magnitude.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH:0] e;
        e = {sgn & v[WIDTH-1], v};
        return e[WIDTH] ? -e : e;
    endfunction

    assign b_sel     = sq ? a : b;
    assign accept    = in_valid && (state == IDLE);
    assign last_iter = (count == CW'(WIDTH - 1));
    assign acc_sum   = mplier[0] ? (acc + (PW'(mcand) << count)) : acc;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= magnitude(a, is_signed);
            mplier <= magnitude(b_sel, is_signed);
            neg    <= is_signed && (a[WIDTH-1] ^ b_sel[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
        end else if (state == CALC) begin
            acc    <= acc_sum;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last_iter) begin
                product <= neg ? -acc_sum : acc_sum;
            end
        end
    end
endmodule

// File: tb/tb_iter_mult.sv
// Bench for iter_mult at WIDTH=32 and WIDTH=8, checked against plain integer multiplication.
module tb_iter_mult;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid32, in_ready32, sq32, sg32, out_valid32, out_ready32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] product32;

    logic        in_valid8, in_ready8, sq8, sg8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int unsigned errors = 0;
    int unsigned checks = 0;

    iter_mult #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sq(sq32), .is_signed(sg32), .out_valid(out_valid32),
        .out_ready(out_ready32), .product(product32), .busy(busy32)
    );

    iter_mult #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sq(sq8), .is_signed(sg8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input logic sg);
        logic [31:0]        yy;
        logic signed [63:0] sx, sy;
        yy = s ? x : y;
        if (sg) begin
            sx = 64'($signed(x));
            sy = 64'($signed(yy));
            return sx * sy;
        end
        return {32'd0, x} * {32'd0, yy};
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                           input logic s, input logic sg);
        logic [7:0]         yy;
        logic signed [15:0] sx, sy;
        yy = s ? x : y;
        if (sg) begin
            sx = 16'($signed(x));
            sy = 16'($signed(yy));
            return sx * sy;
        end
        return {8'd0, x} * {8'd0, yy};
    endfunction

    task automatic op32(input logic [31:0] ta, input logic [31:0] tb, input logic tsq,
                        input logic tsg, input logic [63:0] exp, input string nm);
        int unsigned cyc;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b1) begin
            errors++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready32);
        end
        in_valid32 = 1'b1; a32 = ta; b32 = tb; sq32 = tsq; sg32 = tsg;
        @(negedge clk);
        // Scramble inputs after the accept edge; they must not matter.
        in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom; sq32 = 1'($urandom); sg32 = 1'($urandom);
        cyc = 0;
        while (out_valid32 !== 1'b1 && cyc < 200) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc != 32) begin
            errors++; $display("FAIL %s latency: got %0d want 32", nm, cyc);
        end
        checks++;
        if (product32 !== exp) begin
            errors++; $display("FAIL %s product: got %h want %h", nm, product32, exp);
        end
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || product32 !== exp) begin
            errors++;
            $display("FAIL %s handshake: got ov=%b ir=%b p=%h want ov=0 ir=1 p=%h",
                     nm, out_valid32, in_ready32, product32, exp);
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsq,
                       input logic tsg, input logic [15:0] exp, input string nm);
        int unsigned cyc;
        @(negedge clk);
        in_valid8 = 1'b1; a8 = ta; b8 = tb; sq8 = tsq; sg8 = tsg;
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sq8 = 1'($urandom); sg8 = 1'($urandom);
        cyc = 0;
        while (out_valid8 !== 1'b1 && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc != 8) begin
            errors++; $display("FAIL %s latency: got %0d want 8", nm, cyc);
        end
        checks++;
        if (product8 !== exp) begin
            errors++; $display("FAIL %s product: got %h want %h", nm, product8, exp);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++; $display("FAIL %s handshake: got ov=%b ir=%b want ov=0 ir=1", nm, out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || busy32 !== 1'b0 || product32 !== 64'd0) begin
            errors++;
            $display("FAIL reset32: got ir=%b ov=%b busy=%b p=%h want 1 0 0 0",
                     in_ready32, out_valid32, busy32, product32);
        end
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || product8 !== 16'd0) begin
            errors++;
            $display("FAIL reset8: got ir=%b ov=%b busy=%b p=%h want 1 0 0 0",
                     in_ready8, out_valid8, busy8, product8);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed32;
        op32(32'd5, 32'h1234_5678, 1'b1, 1'b0, 64'd25, "sq5");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'h0000_0000_0000_0001, "sneg1");
        op32(32'h8000_0000, 32'h0, 1'b1, 1'b1, 64'h4000_0000_0000_0000, "smin_sq");
        op32(32'h8000_0000, 32'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, "smin_x1");
        op32(32'h0, 32'h0, 1'b0, 1'b1, 64'h0, "zero");
    endtask

    task automatic test_directed8;
        logic [7:0] g;
        op8(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, "u8max");
        op8(8'h7F, 8'h80, 1'b0, 1'b1, 16'hC080, "s8mix");
        op8(8'h80, 8'h80, 1'b0, 1'b1, 16'h4000, "s8min");
        for (int i = 0; i < 4; i++) begin
            g = 8'($urandom);
            op8(8'h9C, g, 1'b1, 1'(i), model8(8'h9C, 8'h9C, 1'b0, 1'(i)), "sq8garbage");
        end
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        logic [7:0]  p, q;
        logic        s, g;
        for (int i = 0; i < 40; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom_range(0, 3) == 0); g = 1'($urandom);
            if (i < 4) x = {x[31], 31'(x[31] ? 0 : 32'h7FFF_FFFF)};
            op32(x, y, s, g, model32(x, y, s, g), "rand32");
        end
        for (int i = 0; i < 40; i++) begin
            p = 8'($urandom); q = 8'($urandom); s = 1'($urandom_range(0, 3) == 0); g = 1'($urandom);
            op8(p, q, s, g, model8(p, q, s, g), "rand8");
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] fa, fb, na, nb;
        logic [63:0] exp1, exp2;
        int unsigned cyc;
        fa = $urandom; fb = $urandom; na = $urandom; nb = $urandom;
        exp1 = model32(fa, fb, 1'b0, 1'b0);
        exp2 = model32(na, nb, 1'b0, 1'b1);
        @(negedge clk);
        in_valid32 = 1'b1; a32 = fa; b32 = fb; sq32 = 1'b0; sg32 = 1'b0;
        @(negedge clk);
        a32 = na; b32 = nb; sg32 = 1'b1;
        cyc = 0;
        while (out_valid32 !== 1'b1 && cyc < 200) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc != 32 || product32 !== exp1) begin
            errors++; $display("FAIL bp_first: got lat=%0d p=%h want lat=32 p=%h", cyc, product32, exp1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0 || product32 !== exp1) begin
                errors++;
                $display("FAIL bp_hold: got ov=%b ir=%b p=%h want ov=1 ir=0 p=%h",
                         out_valid32, in_ready32, product32, exp1);
            end
        end
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got ov=%b ir=%b busy=%b want 0 1 0", out_valid32, in_ready32, busy32);
        end
        @(negedge clk);
        in_valid32 = 1'b0;
        checks++;
        if (busy32 !== 1'b1 || product32 !== exp1) begin
            errors++; $display("FAIL bp_accept: got busy=%b p=%h want busy=1 p=%h", busy32, product32, exp1);
        end
        cyc = 0;
        while (out_valid32 !== 1'b1 && cyc < 200) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc != 32 || product32 !== exp2) begin
            errors++; $display("FAIL bp_second: got lat=%0d p=%h want lat=32 p=%h", cyc, product32, exp2);
        end
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int unsigned seen;
        @(negedge clk);
        in_valid32 = 1'b1; a32 = 32'h0001_2345; b32 = 32'h0000_0777; sq32 = 1'b0; sg32 = 1'b0;
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || busy32 !== 1'b0 || product32 !== 64'd0) begin
            errors++;
            $display("FAIL midreset: got ir=%b ov=%b busy=%b p=%h want 1 0 0 0",
                     in_ready32, out_valid32, busy32, product32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid32 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midreset_nopulse: got %0d valid cycles want 0", seen);
        end
        op32(32'hDEAD_BEEF, 32'h8765_4321, 1'b0, 1'b1,
             model32(32'hDEAD_BEEF, 32'h8765_4321, 1'b0, 1'b1), "after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; sq32 = 1'b0; sg32 = 1'b0; out_ready32 = 1'b0;
        in_valid8 = 1'b0;  a8 = '0;  b8 = '0;  sq8 = 1'b0;  sg8 = 1'b0;  out_ready8 = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_directed32;
        test_directed8;
        test_random;
        test_backpressure;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
